// File: rtl/xyz_sweep_pkg.sv
// rtl/xyz_sweep_pkg.sv - shared states and constants for the xyz truth-table sweeper
package xyz_sweep_pkg;

  localparam int N_VEC = 8;
  localparam int IDX_W = 3;

  localparam logic [7:0] DEF_EXP_F1 = 8'h93;
  localparam logic [7:0] DEF_EXP_F2 = 8'h93;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/xyz_truth_sweep_rise_pulse.sv
// rtl/xyz_truth_sweep_rise_pulse.sv - register plus AND-NOT rising-edge detector
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic pulse_o
);

  logic in_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in_i;
      armed_q <= 1'b1;
    end
  end

  // A level already high when reset releases is not treated as an edge.
  assign pulse_o = in_i & ~in_q & armed_q;

endmodule

// File: rtl/xyz_truth_sweep.sv
// rtl/xyz_truth_sweep.sv - sweeps {x,y,z} through 0..7 and captures f1/f2 truth tables; optional TRUTH_CHECK_EN adds pass/fail
module xyz_truth_sweep
  import xyz_sweep_pkg::*;
#(
  parameter int DWELL_CYCLES  = 50000000,
  parameter int CNT_W         = 26,
  parameter int SETTLE_CYCLES = 2
`ifdef TRUTH_CHECK_EN
  ,
  parameter logic [7:0] EXP_F1 = DEF_EXP_F1,
  parameter logic [7:0] EXP_F2 = DEF_EXP_F2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step,
  input  logic       mode_auto,
  input  logic       f1,
  input  logic       f2,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [2:0] idx,
  output logic [7:0] tt_f1,
  output logic [7:0] tt_f2,
  output logic       busy,
`ifdef TRUTH_CHECK_EN
  output logic       pass,
  output logic       fail,
`endif
  output logic       done
);

  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VEC - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_VEC-1:0]   tt_f1_q;
  logic [N_VEC-1:0]   tt_f2_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               settling_q;
  logic               auto_q;
  logic               start_p;
  logic               step_p;
`ifdef TRUTH_CHECK_EN
  logic               pass_q;
  logic               fail_q;
  logic               chk_q;
  logic               match;

  assign match = (tt_f1_q == EXP_F1) && (tt_f2_q == EXP_F2);
`endif

  rise_pulse u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (start),
    .pulse_o(start_p)
  );

  rise_pulse u_step_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (step),
    .pulse_o(step_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tt_f1_q    <= '0;
      tt_f2_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      settling_q <= 1'b0;
      auto_q     <= 1'b0;
`ifdef TRUTH_CHECK_EN
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      chk_q      <= 1'b0;
`endif
    end else begin
`ifdef TRUTH_CHECK_EN
      if (chk_q) begin
        pass_q <= match;
        fail_q <= ~match;
        chk_q  <= 1'b0;
      end
`endif
      // Start wins over every state, including the SAMPLE cycle.
      if (start_p) begin
        state_q    <= HOLD;
        idx_q      <= '0;
        tt_f1_q    <= '0;
        tt_f2_q    <= '0;
        cnt_q      <= '0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        settling_q <= 1'b0;
        auto_q     <= mode_auto;
`ifdef TRUTH_CHECK_EN
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
        chk_q      <= 1'b0;
`endif
      end else begin
        case (state_q)
          HOLD: begin
            if (auto_q) begin
              if (cnt_q == DWELL_LAST) state_q <= SAMPLE;
              else                     cnt_q   <= cnt_q + 1'b1;
            end else if (!settling_q) begin
              if (step_p) begin
                settling_q <= 1'b1;
                cnt_q      <= '0;
              end
            end else begin
              if (cnt_q == SETTLE_LAST) state_q <= SAMPLE;
              else                      cnt_q   <= cnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            tt_f1_q[idx_q] <= f1;
            tt_f2_q[idx_q] <= f2;
            if (idx_q == IDX_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
`ifdef TRUTH_CHECK_EN
              chk_q   <= 1'b1;
`endif
            end else begin
              idx_q      <= idx_q + 1'b1;
              cnt_q      <= '0;
              settling_q <= 1'b0;
              auto_q     <= mode_auto;
              state_q    <= HOLD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign x     = idx_q[2];
  assign y     = idx_q[1];
  assign z     = idx_q[0];
  assign idx   = idx_q;
  assign tt_f1 = tt_f1_q;
  assign tt_f2 = tt_f2_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef TRUTH_CHECK_EN
  assign pass  = pass_q;
  assign fail  = fail_q;
`endif

endmodule

// File: tb/tb_xyz_truth_sweep.sv
// tb/tb_xyz_truth_sweep.sv - scoreboard bench for xyz_truth_sweep with a behavioural function block
module tb_xyz_truth_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       mode_auto = 1'b1;
  logic       f1;
  logic       f2;
  logic       x;
  logic       y;
  logic       z;
  logic [2:0] idx;
  logic [7:0] tt_f1;
  logic [7:0] tt_f2;
  logic       busy;
  logic       done;
`ifdef TRUTH_CHECK_EN
  logic       pass;
  logic       fail;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int model_sel = 0;
  logic [15:0] exp_q[$];
  logic [2:0] v;
  logic mt;

  xyz_truth_sweep #(
    .DWELL_CYCLES (4),
    .CNT_W        (8),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .step     (step),
    .mode_auto(mode_auto),
    .f1       (f1),
    .f2       (f2),
    .x        (x),
    .y        (y),
    .z        (z),
    .idx      (idx),
    .tt_f1    (tt_f1),
    .tt_f2    (tt_f2),
    .busy     (busy),
`ifdef TRUTH_CHECK_EN
    .pass     (pass),
    .fail     (fail),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  // Function block under test: 0 = minterms{0,1,4,7}, 1 = (z, x), 2 = f1 stuck low
  assign v = {x, y, z};
  always_comb begin
    mt = (v == 3'd0) || (v == 3'd1) || (v == 3'd4) || (v == 3'd7);
    f1 = mt;
    f2 = mt;
    case (model_sel)
      1: begin f1 = z; f2 = x; end
      2: begin f1 = 1'b0; f2 = mt; end
      default: ;
    endcase
  end

  function automatic logic [15:0] pop_exp();
    if (exp_q.size() == 0) return 16'hxxxx;
    return exp_q.pop_front();
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_step();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int c;
    c = 0;
    while (done !== 1'b1 && c < lim) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      $display("FAIL wait_done: done=%b required 1 within %0d cycles", done, lim);
      n_mis++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mode_auto = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({x, y, z, idx, busy, done} !== 8'h00) begin
      $display("FAIL reset_outputs: got xyz=%b%b%b idx=%0d busy=%b done=%b, required all 0", x, y, z, idx, busy, done);
      n_mis++;
    end
    n_cmp++;
    if ({tt_f1, tt_f2} !== 16'h0000) begin
      $display("FAIL reset_tables: got %h/%h, required 00/00", tt_f1, tt_f2);
      n_mis++;
    end
`ifdef TRUTH_CHECK_EN
    n_cmp++;
    if ({pass, fail} !== 2'b00) begin
      $display("FAIL reset_passfail: got pass=%b fail=%b, required 0/0", pass, fail);
      n_mis++;
    end
`endif
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || idx !== 3'd0) begin
      $display("FAIL reset_no_sweep: got busy=%b idx=%0d, required busy=0 idx=0", busy, idx);
      n_mis++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_auto_sweep();
    int e_idx;
    logic [15:0] e;
    model_sel = 0; mode_auto = 1'b1;
    exp_q.push_back(16'h9393);
    pulse_start();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      e_idx = (c / 5 > 7) ? 7 : c / 5;
      n_cmp++;
      if (idx !== 3'(e_idx) || {x, y, z} !== 3'(e_idx) || done !== (c >= 40) || busy !== (c < 40)) begin
        $display("FAIL auto_cycle%0d: got idx=%0d xyz=%b%b%b done=%b busy=%b, required idx=%0d done=%b busy=%b",
                 c, idx, x, y, z, done, busy, e_idx, c >= 40, c < 40);
        n_mis++;
      end
    end
    e = pop_exp();
    n_cmp++;
    if ({tt_f1, tt_f2} !== e) begin
      $display("FAIL auto_tables: got %h/%h, required %h/%h", tt_f1, tt_f2, e[15:8], e[7:0]);
      n_mis++;
    end
`ifdef TRUTH_CHECK_EN
    n_cmp++;
    if (pass !== 1'b0) begin
      $display("FAIL auto_pass_early: got pass=%b on done cycle, required 0", pass);
      n_mis++;
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      $display("FAIL auto_pass: got pass=%b fail=%b, required 1/0", pass, fail);
      n_mis++;
    end
`endif
  endtask

  task automatic test_manual();
    logic [15:0] e;
    model_sel = 1; mode_auto = 1'b0;
    exp_q.push_back(16'hAAF0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (idx !== 3'(i) || busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL manual_step%0d: got idx=%0d busy=%b done=%b, required idx=%0d busy=1 done=0", i, idx, busy, done, i);
        n_mis++;
      end
      pulse_step();
      repeat (10) @(posedge clk);
    end
    @(negedge clk);
    e = pop_exp();
    n_cmp++;
    if ({tt_f1, tt_f2} !== e || done !== 1'b1) begin
      $display("FAIL manual_tables: got %h/%h done=%b, required %h/%h done=1", tt_f1, tt_f2, done, e[15:8], e[7:0]);
      n_mis++;
    end
    pulse_step();
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (idx !== 3'd7 || done !== 1'b1 || {tt_f1, tt_f2} !== 16'hAAF0) begin
      $display("FAIL manual_ninth_step: got idx=%0d done=%b tables=%h/%h, required 7/1/aa/f0", idx, done, tt_f1, tt_f2);
      n_mis++;
    end
`ifdef TRUTH_CHECK_EN
    n_cmp++;
    if (pass !== 1'b0 || fail !== 1'b1) begin
      $display("FAIL manual_fail_flag: got pass=%b fail=%b, required 0/1", pass, fail);
      n_mis++;
    end
`endif
  endtask

  task automatic test_restart();
    int c;
    logic [15:0] e;
    model_sel = 0; mode_auto = 1'b1;
    pulse_start();
    c = 0;
    while (idx !== 3'd5 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (idx !== 3'd5 || {tt_f1, tt_f2} !== 16'h1313) begin
      $display("FAIL restart_partial: got idx=%0d tables=%h/%h, required idx=5 tables=13/13", idx, tt_f1, tt_f2);
      n_mis++;
    end
    exp_q.push_back(16'h9393);
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (idx !== 3'd0 || {tt_f1, tt_f2} !== 16'h0000 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL restart_clear: got idx=%0d tables=%h/%h busy=%b done=%b, required 0/00/00/1/0", idx, tt_f1, tt_f2, busy, done);
      n_mis++;
    end
    wait_done(100);
    e = pop_exp();
    n_cmp++;
    if ({tt_f1, tt_f2} !== e) begin
      $display("FAIL restart_tables: got %h/%h, required %h/%h", tt_f1, tt_f2, e[15:8], e[7:0]);
      n_mis++;
    end
  endtask

  task automatic test_step_settle();
    model_sel = 1; mode_auto = 1'b0;
    pulse_start();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (idx !== 3'd1 || busy !== 1'b1) begin
      $display("FAIL settle_step: got idx=%0d busy=%b, required idx=1 busy=1", idx, busy);
      n_mis++;
    end
  endtask

  task automatic test_wrong_dut();
    logic [15:0] e;
    model_sel = 2; mode_auto = 1'b1;
    exp_q.push_back(16'h0093);
    pulse_start();
    wait_done(100);
    e = pop_exp();
    n_cmp++;
    if ({tt_f1, tt_f2} !== e) begin
      $display("FAIL wrong_tables: got %h/%h, required %h/%h", tt_f1, tt_f2, e[15:8], e[7:0]);
      n_mis++;
    end
`ifdef TRUTH_CHECK_EN
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (pass !== 1'b0 || fail !== 1'b1) begin
      $display("FAIL wrong_fail_flag: got pass=%b fail=%b, required 0/1", pass, fail);
      n_mis++;
    end
`endif
  endtask

  task automatic test_reset_mid();
    model_sel = 0; mode_auto = 1'b1;
    pulse_start();
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({idx, busy, done, tt_f1, tt_f2} !== 21'h0) begin
      $display("FAIL reset_mid: got idx=%0d busy=%b done=%b tables=%h/%h, required all 0", idx, busy, done, tt_f1, tt_f2);
      n_mis++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_auto_sweep();
    test_manual();
    test_restart();
    test_step_settle();
    test_wrong_dut();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
